// File: rtl/digit_store_n_if.sv
// Keypad-to-digit-store bundle: keypad side drives digit/valid/clear/backspace,
// the store returns its digits and status.
interface digit_store_n_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [DIGIT_W-1:0]        digit;
    logic                      valid;
    logic                      clear;
    logic                      backspace;
    logic [DIGITS*DIGIT_W-1:0] out;
    logic [DIGITS-1:0]         digitsToDisplay;
    logic                      storageFull;
    logic                      overflow;
    logic [CNT_W-1:0]          count;

    modport master (
        output digit, valid, clear, backspace,
        input  out, digitsToDisplay, storageFull, overflow, count
    );

    modport slave (
        input  digit, valid, clear, backspace,
        output out, digitsToDisplay, storageFull, overflow, count
    );
endinterface

// File: rtl/digit_store_n.sv
// Calculator-style keypad digit store: newest digit in slot 0, edge-qualified
// entry/backspace, overflow pulse. Optional idle auto-clear: DIGITSTORE_TIMEOUT_EN.
module digit_store_n #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    digit_store_n_if.slave   bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [DIGIT_W-1:0] slot_reg  [DIGITS];
    logic [DIGIT_W-1:0] slot_next [DIGITS];
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               valid_q_reg, backspace_q_reg;
    logic               overflow_reg, overflow_next;
    logic               dig_ev, bs_ev;
    logic               timeout_hit;

    assign dig_ev = bus.valid & ~valid_q_reg;
    assign bs_ev  = bus.backspace & ~backspace_q_reg;

    always_comb begin
        slot_next     = slot_reg;
        count_next    = count_reg;
        overflow_next = 1'b0;
        if (bus.clear || timeout_hit) begin
            for (int i = 0; i < DIGITS; i++) slot_next[i] = '0;
            count_next = '0;
        end else if (bs_ev) begin
            if (count_reg != '0) begin
                for (int i = 0; i < DIGITS - 1; i++) slot_next[i] = slot_reg[i+1];
                slot_next[DIGITS-1] = '0;
                count_next = count_reg - CNT_W'(1);
            end
        end else if (dig_ev) begin
            if (count_reg < CNT_W'(DIGITS)) begin
                for (int i = DIGITS - 1; i > 0; i--) slot_next[i] = slot_reg[i-1];
                slot_next[0] = bus.digit;
                count_next = count_reg + CNT_W'(1);
            end else begin
                overflow_next = 1'b1;
            end
        end
    end

    // Edge history keeps tracking during clear so a held key cannot re-fire on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIGITS; i++) slot_reg[i] <= '0;
            count_reg       <= '0;
            valid_q_reg     <= 1'b0;
            backspace_q_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            slot_reg        <= slot_next;
            count_reg       <= count_next;
            valid_q_reg     <= bus.valid;
            backspace_q_reg <= bus.backspace;
            overflow_reg    <= overflow_next;
        end
    end

`ifdef DIGITSTORE_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IDLE_W-1:0] idle_reg, idle_next;

    // Any user activity restarts the window; an empty store never times out.
    always_comb begin
        idle_next   = '0;
        timeout_hit = 1'b0;
        if (count_reg != '0 && !(bus.clear || bs_ev || dig_ev)) begin
            if (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
            else                                         idle_next   = idle_reg + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idle_reg <= '0;
        else        idle_reg <= idle_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign bus.out[gi*DIGIT_W +: DIGIT_W] = slot_reg[gi];
            assign bus.digitsToDisplay[gi]        = (count_reg > CNT_W'(gi));
        end
    endgenerate

    assign bus.count       = count_reg;
    assign bus.storageFull = (count_reg == CNT_W'(DIGITS));
    assign bus.overflow    = overflow_reg;
endmodule

// File: tb/tb_digit_store_n.sv
// Scoreboard bench for digit_store_n: 4-digit store against a calculator model,
// plus a 6-digit store (timeout window exercised when DIGITSTORE_TIMEOUT_EN is set).
module tb_digit_store_n;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    digit_store_n_if #(.DIGITS(4), .DIGIT_W(4)) ifc ();
    digit_store_n_if #(.DIGITS(6), .DIGIT_W(4)) ifc6 ();

    digit_store_n #(.DIGITS(4), .DIGIT_W(4), .TIMEOUT_CYCLES(50000000)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave)
    );

    digit_store_n #(.DIGITS(6), .DIGIT_W(4), .TIMEOUT_CYCLES(8)) dut6 (
        .clk(clk), .reset(reset), .bus(ifc6.slave)
    );

    typedef struct {
        logic [15:0] out;
        int          cnt;
        bit          ovf;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_out;
    int          m_cnt;
    bit          m_vq, m_bq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0;
        m_cnt = 0;
        m_vq  = 1'b0;
        m_bq  = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the store contents after the edge, then compare.
    task automatic step(input bit v, input logic [3:0] d, input bit c, input bit b);
        exp_t e, g;
        bit dev, bev;
        ifc.valid = v; ifc.digit = d; ifc.clear = c; ifc.backspace = b;
        dev = v && !m_vq;
        bev = b && !m_bq;
        m_vq = v;
        m_bq = b;
        e.ovf = 1'b0;
        if (c) begin
            m_out = '0; m_cnt = 0;
        end else if (bev) begin
            if (m_cnt > 0) begin m_out = m_out >> 4; m_cnt--; end
        end else if (dev) begin
            if (m_cnt < 4) begin m_out = (m_out << 4) | {12'h000, d}; m_cnt++; end
            else e.ovf = 1'b1;
        end
        e.out = m_out;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            g = sb.pop_front();
            check("out",      64'(ifc.out),             64'(g.out));
            check("count",    64'(ifc.count),           64'(g.cnt));
            check("mask",     64'(ifc.digitsToDisplay), 64'((1 << g.cnt) - 1));
            check("full",     64'(ifc.storageFull),     64'(g.cnt == 4));
            check("overflow", 64'(ifc.overflow),        64'(g.ovf));
        end
        $display("step v=%0b d=%h c=%0b b=%0b -> out=%h count=%0d ovf=%0b",
                 v, d, c, b, ifc.out, ifc.count, ifc.overflow);
    endtask

    task automatic pulse(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic bspace();
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic pulse6(input logic [3:0] d);
        ifc6.valid = 1'b1; ifc6.digit = d;
        @(posedge clk); #1;
        ifc6.valid = 1'b0;
        @(posedge clk); #1;
        $display("dut6 digit %h -> out=%h count=%0d", d, ifc6.out, ifc6.count);
    endtask

    initial begin
        ifc.valid = 0; ifc.digit = 0; ifc.clear = 0; ifc.backspace = 0;
        ifc6.valid = 0; ifc6.digit = 0; ifc6.clear = 0; ifc6.backspace = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",   64'(ifc.out), 64'h0);
        check("rst_count", 64'(ifc.count), 64'h0);
        check("rst_mask",  64'(ifc.digitsToDisplay), 64'h0);
        check("rst_full",  64'(ifc.storageFull), 64'h0);
        check("rst_ovf",   64'(ifc.overflow), 64'h0);
        @(negedge clk) reset = 1'b1;

        // Fill to capacity, then one rejected digit
        pulse(4'h0); pulse(4'hA); pulse(4'hA); pulse(4'hA);
        check("fill_out",  64'(ifc.out), 64'h0AAA);
        check("fill_full", 64'(ifc.storageFull), 64'h1);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        check("reject_ovf", 64'(ifc.overflow), 64'h1);
        step(1'b0, 4'h5, 1'b0, 1'b0);
        check("reject_out", 64'(ifc.out), 64'h0AAA);
        check("ovf_drop",   64'(ifc.overflow), 64'h0);

        // Held valid yields exactly one digit
        step(1'b0, 4'h0, 1'b1, 1'b0);
        pulse(4'h1); pulse(4'h2); pulse(4'h3);
        for (int i = 0; i < 10; i++) step(1'b1, 4'h7, 1'b0, 1'b0);
        step(1'b0, 4'h7, 1'b0, 1'b0);
        check("held_out", 64'(ifc.out), 64'h1237);

        // Backspace down to empty, one extra no-op
        step(1'b0, 4'h0, 1'b1, 1'b0);
        pulse(4'h1); pulse(4'h2); pulse(4'h3);
        bspace();
        check("bs_out",  64'(ifc.out), 64'h0012);
        check("bs_mask", 64'(ifc.digitsToDisplay), 64'h3);
        bspace(); bspace(); bspace();
        check("bs_empty", 64'(ifc.count), 64'h0);

        // Clear beats a digit edge; valid held across clear release is swallowed
        pulse(4'h4); pulse(4'h5); pulse(4'h6);
        step(1'b1, 4'h9, 1'b1, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h9, 1'b0, 1'b0);
        check("clr_count", 64'(ifc.count), 64'h0);

        // Backspace and digit edges together: backspace wins
        pulse(4'h8); pulse(4'h9);
        step(1'b1, 4'h4, 1'b0, 1'b1);
        step(1'b0, 4'h4, 1'b0, 1'b0);
        check("bs_wins", 64'(ifc.out), 64'h0008);

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));

        // Asynchronous reset mid-cycle, with valid already high at release
        step(1'b0, 4'h0, 1'b1, 1'b0);
        pulse(4'hC); pulse(4'hD);
        ifc.valid = 1'b1; ifc.digit = 4'hE;
        #2 reset = 1'b0;
        #1;
        check("arst_out",   64'(ifc.out), 64'h0);
        check("arst_count", 64'(ifc.count), 64'h0);
        check("arst_mask",  64'(ifc.digitsToDisplay), 64'h0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        step(1'b1, 4'hE, 1'b0, 1'b0);
        step(1'b0, 4'hE, 1'b0, 1'b0);
        check("rel_event", 64'(ifc.out), 64'h000E);

        // Six-digit instance: capacity and overflow
        for (int i = 1; i <= 6; i++) pulse6(4'(i));
        check("d6_out",  64'(ifc6.out), 64'h123456);
        check("d6_full", 64'(ifc6.storageFull), 64'h1);
        ifc6.valid = 1'b1; ifc6.digit = 4'h7;
        @(posedge clk); #1;
        check("d6_ovf", 64'(ifc6.overflow), 64'h1);
        ifc6.valid = 1'b0;
        @(posedge clk); #1;
        check("d6_ovf_drop", 64'(ifc6.overflow), 64'h0);
        check("d6_keep",     64'(ifc6.out), 64'h123456);
        ifc6.clear = 1'b1;
        @(posedge clk); #1;
        ifc6.clear = 1'b0;
        check("d6_clear", 64'(ifc6.count), 64'h0);

`ifdef DIGITSTORE_TIMEOUT_EN
        pulse6(4'h1); pulse6(4'h2);
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            check("to_hold", 64'(ifc6.count), 64'h2);
        end
        @(posedge clk); #1;
        check("to_clear", 64'(ifc6.count), 64'h0);
        check("to_out",   64'(ifc6.out), 64'h0);
        pulse6(4'h1); pulse6(4'h2);
        repeat (3) @(posedge clk);
        #1;
        pulse6(4'h3);
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            check("to_restart", 64'(ifc6.count), 64'h3);
        end
        @(posedge clk); #1;
        check("to_clear2", 64'(ifc6.count), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/digit_store_n.md
Name: digit_store_n

Overview:
- Parametrised successor to the keypad digit store.
- Collects keypad digits into a shift register DIGITS entries deep. Each entry is DIGIT_W bits wide. The newest digit is always in the least-significant slot, as on a calculator.
- Adds edge-qualified strobes, backspace, overflow reporting and a thermometer display mask.
- Sits between the keypad decoder and the display driver / code comparator in the security device.

Parameters:
- DIGITS, 4, number of digit slots (min 1).
- DIGIT_W, 4, bits per digit.
- TIMEOUT_CYCLES, 50000000, idle cycles before auto-clear (used only with DIGITSTORE_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- digit  input  DIGIT_W  digit value from keypad decoder; sampled only when a valid edge is detected.
- valid  input  1  digit-present level from keypad.
- clear  input  1  clear-all request, level-sensitive.
- backspace  input  1  delete-newest request level from keypad.
- out  output  DIGITS*DIGIT_W  stored digits; slot i = out[i*DIGIT_W +: DIGIT_W], slot 0 = newest.
- digitsToDisplay  output  DIGITS  thermometer mask; bit i = 1 iff i < count.
- storageFull  output  1  1 iff count == DIGITS.
- overflow  output  1  one-cycle pulse when a digit is rejected because storage is full.
- count  output  $clog2(DIGITS+1)  number of stored digits, 0..DIGITS.

Behaviour:
- Reset (reset = 0, asynchronous): out = 0, count = 0, digitsToDisplay = 0, storageFull = 0, overflow = 0, edge-detect history registers = 0. Outputs hold these values while reset is low.
- Edge detection:
  - Internal registers valid_q and backspace_q hold the previous-cycle input values.
  - dig_ev = valid & ~valid_q.
  - bs_ev = backspace & ~backspace_q.
  - Holding valid or backspace high for many cycles produces exactly one event.
  - After reset release, an input already high produces an event on the first clock.
- Priority each cycle: clear > bs_ev > dig_ev. Only one action is taken per cycle.
- clear:
  - Sets out = 0 and count = 0 on the next edge, whatever count is.
  - While clear is held, edge events are discarded, but valid_q and backspace_q still track their inputs.
  - A valid held across the release of clear therefore produces no event.
- Digit accept (dig_ev, count < DIGITS):
  - Slot i+1 <= slot i for i = DIGITS-2 down to 0.
  - Slot 0 <= digit.
  - count <= count + 1.
- Digit reject (dig_ev, count == DIGITS):
  - out and count are unchanged.
  - overflow = 1 for exactly the following cycle.
- Backspace (bs_ev, count > 0):
  - Slot i <= slot i+1 for i = 0 to DIGITS-2.
  - Top slot <= 0.
  - count <= count - 1.
- Backspace when count == 0: no-op, no overflow.
- Simultaneous bs_ev and dig_ev in the same cycle: backspace wins and the digit event is lost.
- Output timing:
  - digitsToDisplay and storageFull are decoded combinationally from the count register, so they are valid in the same cycle as out.
  - Latency from the input edge to updated out/count is 1 clock.
- All digit values 0..2^DIGIT_W-1 are stored unfiltered.
- Unused slots (index >= count) always read 0.

Optional Feature:
- Macro: DIGITSTORE_TIMEOUT_EN.
- When defined:
  - An idle counter increments every cycle while count > 0.
  - Any clear, bs_ev or dig_ev resets it to 0.
  - When it reaches TIMEOUT_CYCLES-1, the next edge performs a clear (out = 0, count = 0) and the counter returns to 0.
  - The counter is held at 0 while count == 0.
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - Reset sets the counter to 0.
- When not defined: no counter logic; digits persist until clear, backspace or reset. TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset release, then valid pulses with digit = 0, A, A, A (DIGITS = 4) -> out = 16'h0AAA, count = 4, digitsToDisplay = 4'b1111, storageFull = 1, overflow = 0.
- From full state, a fifth valid pulse with digit = 5 -> out stays 16'h0AAA; overflow = 1 for one cycle then 0.
- Load digits 1, 2, 3, then hold valid high for 10 cycles with digit = 7 -> out = 16'h1237, count = 4, only one digit accepted.
- From 16'h0123 (count = 3), one backspace pulse -> out = 16'h0012, count = 2, digitsToDisplay = 4'b0011. Three more backspace pulses -> out = 0, count = 0, no overflow.
- Load 3 digits, assert clear and a valid edge in the same cycle -> out = 0, count = 0 next cycle. Drive reset low mid-sequence -> all outputs 0 immediately, with no clock edge needed.
- DIGITS = 6, DIGIT_W = 4, DIGITSTORE_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8: load 2 digits, then idle -> count = 2 held for 8 cycles, then cleared to 0. A digit entered at idle cycle 5 restarts the 8-cycle window.
